// File: rtl/ei_axi4_reset_ctrl.sv
// rtl/ei_axi4_reset_ctrl.sv - per-channel AXI4 aresetn sequencer
// Power-on reset, immediate/random-delay injection, staggered per-channel release.
module ei_axi4_reset_ctrl #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned MIN_ASSERT = 16,
  parameter int unsigned STAGGER    = 2,
  parameter int unsigned DLY_W      = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              inj_req,
  input  logic              inj_mode,
  input  logic [7:0]        inj_len,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              inj_ack,
  output logic [NUM_CH-1:0] aresetn_o,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rst_count
);

  localparam int unsigned     LEN_MAX  = (MIN_ASSERT > 255) ? MIN_ASSERT : 255;
  localparam int unsigned     LW       = $clog2(LEN_MAX + 1);
  localparam int unsigned     CW       = $clog2(LEN_MAX + (NUM_CH - 1) * STAGGER + 1);
  localparam logic [15:0]     SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [LW-1:0]   MIN_LEN  = LW'(MIN_ASSERT);
  localparam logic [CW-1:0]   LAST_OFS = CW'((NUM_CH - 1) * STAGGER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_ASSERT,
    S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] rstn_q, rstn_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [CW-1:0]     el_q, el_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              inj_q, inj_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [LW-1:0]     clamp_len;
  logic [CW-1:0]     el_inc;
  logic [CW-1:0]     len_ext;

  // el_q counts edges since the low edge; channel i releases when it reaches len_q + i*STAGGER.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    rstn_d    = rstn_q;
    len_d     = len_q;
    dly_d     = dly_q;
    el_d      = el_q;
    cnt_d     = cnt_q;
    inj_d     = inj_q;
    ack_d     = 1'b0;
    done_d    = 1'b0;
    lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    clamp_len = (LW'(inj_len) < MIN_LEN) ? MIN_LEN : LW'(inj_len);
    len_ext   = CW'(len_q);
    el_inc    = el_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (inj_req && (ch_mask != '0)) begin
          ack_d  = 1'b1;
          mask_d = ch_mask;
          len_d  = clamp_len;
          inj_d  = 1'b1;
          if (inj_mode) begin
            dly_d   = lfsr_q[DLY_W-1:0];
            state_d = S_DELAY;
          end else begin
            rstn_d  = rstn_q & ~ch_mask;
            el_d    = '0;
            state_d = S_ASSERT;
          end
        end
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          rstn_d  = rstn_q & ~mask_q;
          el_d    = '0;
          state_d = S_ASSERT;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_ASSERT, S_RELEASE: begin
        el_d = el_inc;
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (mask_q[i] && (el_inc == len_ext + CW'(i * STAGGER))) begin
            rstn_d[i] = 1'b1;
          end
        end
        // Sequence length is set by the last channel slot, masked or not.
        if (el_inc == len_ext + LAST_OFS) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          inj_d   = 1'b0;
          if (inj_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (el_inc == len_ext) begin
          state_d = S_RELEASE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_ASSERT;
      mask_q  <= '1;
      rstn_q  <= '0;
      len_q   <= MIN_LEN;
      dly_q   <= '0;
      el_q    <= '0;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      inj_q   <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rstn_q  <= rstn_d;
      len_q   <= len_d;
      dly_q   <= dly_d;
      el_q    <= el_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      inj_q   <= inj_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign inj_ack   = ack_q;
  assign aresetn_o = rstn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rst_count = cnt_q;

endmodule

// File: doc/ei_axi4_reset_ctrl.md
# ei_axi4_reset_ctrl

Parametrised AXI4 reset sequencer for the VIP environment. It generalises the bench-level single-wire reset pulse into NUM_CH per-interface active-low `aresetn` outputs. It runs a power-on sequence, accepts reset-injection requests in either immediate or pseudo-random-delay mode, and releases channels in a staggered order. It sits between the top-level clock/reset source and the AXI interface instances.

## Interface
- NUM_CH, 2: number of `aresetn` channels, 1..8.
- MIN_ASSERT, 16: minimum reset-low length in cycles, ≥1; also the power-on length.
- STAGGER, 2: cycles between release of channel i and channel i+1, ≥0.
- DLY_W, 8: number of LFSR bits used as random delay, 1..16.
- LFSR_SEED, 16'hACE1: LFSR reset value. 0 is replaced by 16'h0001.

Ports:
- aclk  in  1  clock; all state changes on rising edge.
- areset  in  1  asynchronous, active-high global reset.
- inj_req  in  1  level-held injection request; sampled only in IDLE.
- inj_mode  in  1  0 = immediate, 1 = random delay before assert.
- inj_len  in  8  requested low length in cycles; clamped to max(inj_len, MIN_ASSERT).
- ch_mask  in  NUM_CH  channels affected by the injection.
- inj_ack  out  1  one-cycle pulse: request accepted.
- aresetn_o  out  NUM_CH  per-channel AXI reset, active-low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: sequence complete.
- rst_count  out  16  completed injection sequences, saturating at 16'hFFFF.

## Operation
- States: IDLE, DELAY, ASSERT, RELEASE.
- While areset=1, asynchronously:
  - state=ASSERT, aresetn_o=0, busy=1, inj_ack=0, done=0, rst_count=0.
  - mask_q=all ones, len_q=MIN_ASSERT, lfsr=LFSR_SEED, counters=0.
  - This power-on sequence does not increment rst_count.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifted every cycle out of reset. Delay value = lfsr[DLY_W-1:0].
- IDLE, inj_req=1 and ch_mask≠0 (acceptance edge A):
  - inj_ack=1 for one cycle; capture mask_q=ch_mask and len_q=clamped inj_len.
  - inj_mode=0: go to ASSERT; aresetn_o[i]=0 for masked i on edge A.
  - inj_mode=1: capture dly_q from the LFSR at A; go to DELAY.
- IDLE, inj_req=1 and ch_mask=0: ignored. No ack, state stays IDLE.
- inj_req outside IDLE: ignored, not queued. A request still high when the block returns to IDLE is accepted again; dropping inj_req after ack is the requester's job.
- DELAY: stay dly_q+1 cycles. Masked channels go low on edge A+dly_q+1, then ASSERT.
- ASSERT: masked channels held low for len_q cycles. Unmasked channels keep their current value.
- RELEASE: masked channel i goes high len_q + i·STAGGER cycles after its low edge.
  - Duration is fixed by NUM_CH even when high channels are unmasked.
  - On the edge scheduled for channel NUM_CH-1, go to IDLE: done=1 for one cycle, busy=0, and rst_count+1 (injections only, saturating).
- STAGGER=0: all masked channels release on the same edge.

## Timing
- Power-on: edge 1 = first rising edge with areset=0. Channel i rises on edge MIN_ASSERT + i·STAGGER. done pulses on edge MIN_ASSERT+(NUM_CH-1)·STAGGER.
- Immediate injection:
  - inj_ack and the low transition occur on edge A.
  - Channel i rises at A + len_q + i·STAGGER.
  - done at A + len_q + (NUM_CH-1)·STAGGER.
- Delayed injection:
  - inj_ack on A; low on L = A+dly_q+1.
  - Channel i rises at L + len_q + i·STAGGER.
- areset mid-sequence, any state:
  - All aresetn_o go 0 in the same timestep, with no clock edge needed.
  - rst_count clears; the in-flight injection is discarded.
  - The power-on sequence restarts after deassertion.
- No output glitches: every output is a flop.

## Test plan
- Power-on (NUM_CH=2, MIN_ASSERT=16, STAGGER=2): areset high 3 cycles → aresetn_o=2'b00. ch0 rises at edge 16, ch1 at edge 18. done pulses at edge 18, rst_count=0, busy=0 afterwards.
- Immediate injection: inj_mode=0, ch_mask=2'b10, inj_len=20, accepted at A → inj_ack one cycle, ch0 stays 1. ch1 low from A, rises at A+22. done at A+22, rst_count=1.
- Clamp, plus mask-zero and busy rejection:
  - inj_len=3 → masked channel low for 16 cycles.
  - ch_mask=0 in IDLE → no ack, busy stays 0.
  - inj_req during ASSERT → no ack, sequence unaffected.
- Delayed injection (DLY_W=4, seed 16'hACE1): bench LFSR model predicts dly_q.
  - Low edge = A+dly_q+1; release timing as specified.
  - Two back-to-back injections use the model-predicted, differing delays.
- Async reset mid-ASSERT of an injection with rst_count=3:
  - areset pulse between edges → aresetn_o=0 immediately, rst_count=0.
  - Power-on release at edges 16/18 after deassertion.
- STAGGER=0, NUM_CH=4, ch_mask=4'b1111, inj_len=16 → all four channels rise together at A+16; done at A+16.
